pipe_stage_buf: RTL

Parametrised elastic pipeline-stage register for the MISC-V datapath, the successor to the fixed 16-bit IF/ID latch. It carries a PC/IR pair between stages with a valid/ready handshake. A one-entry skid buffer provides full throughput with no combinational path from downstream ready to upstream ready. Flush squashes in-flight instructions to a NOP bubble, and a saturating stall counter supports performance debug.

---
 rtl/pipe_stage_buf.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Elastic PC/IR pipeline stage: main register plus one-entry skid buffer,
// valid/ready handshake, flush-to-bubble and a saturating stall counter.
module pipe_stage_buf #(
    parameter int              PC_WIDTH  = 16,
    parameter int              IR_WIDTH  = 16,
    parameter logic [IR_WIDTH-1:0] NOP_IR = '0,
    parameter int              CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [PC_WIDTH-1:0]  IPC,
    input  logic [IR_WIDTH-1:0]  IIR,
    input  logic                 Flush,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [PC_WIDTH-1:0]  OPC,
    output logic [IR_WIDTH-1:0]  OIR,
    output logic [1:0]           Occupancy,
    output logic [CNT_WIDTH-1:0] StallCnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [PC_WIDTH-1:0]   main_pc_reg, skid_pc_reg;
    logic [IR_WIDTH-1:0]   main_ir_reg, skid_ir_reg;
    logic [CNT_WIDTH-1:0]  stall_cnt_reg;

    logic accept, take;
    logic load_main_in, load_skid, load_main_skid;

    // State register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_next = state_reg;
        if (Flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: if (accept) state_next = ONE;
                ONE: begin
                    if (accept && !take)      state_next = FULL;
                    else if (take && !accept) state_next = EMPTY;
                end
                FULL:  if (take) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    // Output / datapath-control logic; ready depends on registered state only
    always_comb begin
        InReady        = (state_reg != FULL);
        OutValid       = (state_reg != EMPTY);
        Occupancy      = state_reg;
        OPC            = main_pc_reg;
        OIR            = OutValid ? main_ir_reg : NOP_IR;
        StallCnt       = stall_cnt_reg;
        accept         = InValid && InReady;
        take           = OutValid && OutReady;
        load_main_in   = !Flush && accept &&
                         ((state_reg == EMPTY) || ((state_reg == ONE) && take));
        load_skid      = !Flush && accept && (state_reg == ONE) && !take;
        load_main_skid = !Flush && (state_reg == FULL) && take;
    end

    // Main register keeps its last PC after it empties so OPC stays stable
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            main_pc_reg <= '0;
            main_ir_reg <= '0;
        end else if (load_main_in) begin
            main_pc_reg <= IPC;
            main_ir_reg <= IIR;
        end else if (load_main_skid) begin
            main_pc_reg <= skid_pc_reg;
            main_ir_reg <= skid_ir_reg;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            skid_pc_reg <= '0;
            skid_ir_reg <= '0;
        end else if (load_skid) begin
            skid_pc_reg <= IPC;
            skid_ir_reg <= IIR;
        end
    end

    // Stall counter survives flush; only reset clears it
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            stall_cnt_reg <= '0;
        end else if (OutValid && !OutReady && (stall_cnt_reg != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

endmodule
